// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;

    // Scan-code prefixes the CPU-side peripheral decodes.
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXTEND = 8'hE0;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic ps2_odd_ok(input logic [7:0] b, input logic p);
        return (^b) ^ p;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// CPU-side read port of the PS/2 receiver: FIFO pop, status and error flags.
interface ps2_keyboard_rx_if;
    logic       rd_en;
    logic       clr_overflow;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overflow;

    // CPU peripheral side
    modport master (
        output rd_en, clr_overflow,
        input  rd_data, rd_valid, frame_err, overflow
    );

    // Receiver side
    modport slave (
        input  rd_en, clr_overflow,
        output rd_data, rd_valid, frame_err, overflow
    );
endinterface

// File: rtl/ps2_keyboard_rx_fifo.sv
// First-word-fall-through byte FIFO with a sticky overflow flag.
module ps2_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       CLK_CPU,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clr_overflow,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, do_pop, do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A pop on an empty FIFO is dropped, so a same-cycle push still lands.
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push would need, so full+pop still accepts.
    assign do_push = push & (~full | do_pop);

    assign rd_valid = ~empty;
    assign rd_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

    // Read/write pointers, one extra MSB to tell full from empty
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage; contents are don't-care while empty, so no reset
    always_ff @(posedge CLK_CPU) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

    // Sticky overflow; a new drop wins over a same-cycle clear
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn)                   overflow <= 1'b0;
        else if (push & full & ~do_pop) overflow <= 1'b1;
        else if (clr_overflow)          overflow <= 1'b0;
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: edge detect, frame FSM, inter-edge timeout, byte FIFO.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic             CLK_CPU,
    input  logic             resetn,
    input  logic             keyboard_clock,
    input  logic             keyboard_data,
    ps2_keyboard_rx_if.slave bus
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t    state_q, state_d;
    logic          clk_prev, fall;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tcnt_q;
    logic          err_d, err_q;
    logic          push;

    // Bus idles high, so clk_prev resets to 1 and reset release makes no edge.
    assign fall = clk_prev & ~keyboard_clock;

    // Falling-edge detector and saturating inter-edge cycle counter
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            clk_prev <= 1'b1;
            tcnt_q   <= '0;
        end else begin
            clk_prev <= keyboard_clock;
            if (fall)                  tcnt_q <= '0;
            else if (tcnt_q != TCNT_MAX) tcnt_q <= tcnt_q + 1'b1;
        end
    end

    // Frame FSM registers and the registered error pulse
    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_ok_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_ok_q <= par_ok_d;
            err_q    <= err_d;
        end
    end

    // Next state: timeout mid-frame abandons the byte, otherwise advance on fall
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_ok_d = par_ok_q;
        push     = 1'b0;
        err_d    = 1'b0;
        if (state_q != IDLE && tcnt_q == TCNT_MAX) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    // A high data bit here is just line noise; ignore it quietly.
                    if (keyboard_data == PS2_START_BIT) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d  = {keyboard_data, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ps2_odd_ok(shreg_q, keyboard_data);
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (keyboard_data == PS2_STOP_BIT && par_ok_q) push  = 1'b1;
                    else                                           err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.frame_err = err_q;

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK_CPU      (CLK_CPU),
        .resetn       (resetn),
        .push         (push),
        .push_data    (shreg_q),
        .pop          (bus.rd_en),
        .clr_overflow (bus.clr_overflow),
        .rd_data      (bus.rd_data),
        .rd_valid     (bus.rd_valid),
        .overflow     (bus.overflow)
    );

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver sitting directly downstream of the board-level two-flip-flop synchronisers on the keyboard clock and data pins. Detects falling edges of the synchronised PS/2 clock and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Checks each frame and buffers valid scan-code bytes in a small first-word-fall-through FIFO that the CPU's keyboard peripheral pops. Flags framing, parity, timeout and overflow faults.

## Interface
- `FIFO_DEPTH`, 8, FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 16000, maximum CLK_CPU cycles allowed between falling edges inside a frame (1 ms at 16 MHz).

- `CLK_CPU` in 1: single clock for the whole block.
- `resetn` in 1: asynchronous, active-low reset.
- `keyboard_clock` in 1: PS/2 clock, already synchronised to CLK_CPU.
- `keyboard_data` in 1: PS/2 data, already synchronised to CLK_CPU.
- `rd_en` in 1: pop the FIFO head; ignored when the FIFO is empty.
- `clr_overflow` in 1: clears `overflow`.
- `rd_data` out 8: FIFO head byte; valid only while `rd_valid`=1.
- `rd_valid` out 1: FIFO is not empty.
- `frame_err` out 1: one-cycle pulse on a parity, stop or timeout error.
- `overflow` out 1: sticky; a received byte was dropped because the FIFO was full.

## Operation
- Edge detect: `clk_prev` register; `fall = clk_prev & !keyboard_clock`. Reset value of `clk_prev` is 1 (bus idles high), so reset release never produces a false edge.
- All data sampling happens only in cycles where `fall`=1.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: on `fall` with data=0, go to DATA and clear `bitcnt`. On `fall` with data=1 (no start bit), stay in IDLE; no error is raised.
  - DATA: on `fall`, `shreg <= {data, shreg[7:1]}` and `bitcnt++`. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store `par_ok = ^shreg ^ data` (required value 1, odd parity), then go to STOP.
  - STOP: on `fall`, return to IDLE.
    - If data=1 and `par_ok`=1, push `shreg` into the FIFO.
    - Otherwise pulse `frame_err` and push nothing.
- Timeout: `tcnt` clears on every `fall` and increments otherwise, saturating. In any state other than IDLE, `tcnt == TIMEOUT_CYCLES-1` forces IDLE and pulses `frame_err`; the partial byte is discarded.
- FIFO: pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full means the pointers are equal except for the MSB.
  - Push when full without a same-cycle pop: the byte is dropped and `overflow` is set.
  - Push when full with a same-cycle pop: both are accepted.
  - Pop when empty: ignored, pointers unchanged.
  - Push and pop together on an empty FIFO: the push is accepted and the pop is ignored.
- `overflow`: the set takes priority over `clr_overflow` in the same cycle.
- Reset values:
  - state IDLE; `bitcnt`, `shreg`, `tcnt` and pointers 0.
  - `rd_valid`=0, `rd_data`=0, `frame_err`=0, `overflow`=0.
  - Reset asserted mid-frame drops the frame; the FIFO is emptied.

## Timing
- `fall` is combinational in the first cycle in which `keyboard_clock` reads 0 after reading 1.
- The stop-bit `fall` occurs in cycle N, the byte is written at the end of N, and `rd_valid`=1 with `rd_data` correct in cycle N+1.
- `frame_err` is high for exactly cycle N+1 after the offending `fall` or timeout cycle N.
- The FIFO is first-word-fall-through: a pop at the end of cycle M presents the next entry, or `rd_valid`=0, in cycle M+1.
- Throughput is one byte per frame (≥11 PS/2 clocks, roughly 1 ms). No backpressure is applied to the keyboard.

## Structure
- Package `ps2_pkg` holds:
  - `ps2_state_t` enum (IDLE, DATA, PARITY, STOP).
  - `PS2_START_BIT`=0 and `PS2_STOP_BIT`=1.
  - Scan-code constants used by the CPU peripheral: `PS2_BREAK`=8'hF0 and `PS2_EXTEND`=8'hE0.
- Sub-module `ps2_byte_fifo` (parameterised FWFT synchronous FIFO) contains the storage, pointers, and the full/empty/overflow logic. The top level contains the edge detector, FSM and timeout.

## Test plan
Frames are driven with an 80 µs PS/2 period (1280 CLK_CPU cycles), with data changing mid-high.
- Frame 0x1C with parity 0 and stop 1 -> `rd_valid` high the cycle after the stop edge, `rd_data`=8'h1C, `frame_err` never high.
- Back-to-back frames 0xF0 (parity 1) then 0x1C -> two entries; pops return 8'hF0 then 8'h1C; `rd_valid`=0 after the second pop.
- Frame 0x1C with parity 1 -> `frame_err` one-cycle pulse; `rd_valid` stays 0.
- Frame 0x1C with stop 0 -> `frame_err` pulse and nothing stored. A following good 0xF0 frame is received correctly.
- Five data bits, then the clock held high for 16000 cycles -> `frame_err` pulse and FSM back in IDLE. The next 0x1C frame is received.
- Nine frames 0x01 to 0x09 with no pops -> FIFO holds 0x01 to 0x08 and `overflow`=1 after the 9th.
  - Pop plus `clr_overflow` -> `rd_data`=0x02 next cycle and `overflow`=0.
  - `resetn` pulsed mid-frame -> `rd_valid`=0 immediately and the partial byte is not stored.
